// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// The granted result is captured in a single-entry response register with a valid/ready handshake.
module alu_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_x_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_y_i,
  input  logic [NUM_REQ*4-1:0]     req_select_i,
  output logic [WIDTH-1:0]         alu_x_o,
  output logic [WIDTH-1:0]         alu_y_o,
  output logic [3:0]               alu_select_o,
  input  logic [WIDTH-1:0]         alu_result_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [IDW-1:0]           rsp_id_o,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     rsp_err_o
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  logic             can_issue;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   gnt_next;
  logic [WIDTH-1:0] gnt_x;
  logic [WIDTH-1:0] gnt_y;
  logic [3:0]       gnt_sel;
  logic             sel_legal;

  function automatic logic is_legal_sel(input logic [3:0] sel);
    logic legal;
    case (sel)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Scan from rr_ptr upward with wrap; the reset term keeps ALU inputs and strobes quiet in reset.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    can_issue = !rsp_valid_q || rsp_ready_i;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_x     = '0;
    gnt_y     = '0;
    gnt_sel   = '0;
    if (rst_ni && can_issue) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (!gnt_valid && req_valid_i[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDW'(idx);
          gnt_x     = req_x_i[idx*WIDTH +: WIDTH];
          gnt_y     = req_y_i[idx*WIDTH +: WIDTH];
          gnt_sel   = req_select_i[idx*4 +: 4];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = gnt_valid && (gnt_idx == IDW'(i));
    end
  end

  assign alu_x_o      = gnt_x;
  assign alu_y_o      = gnt_y;
  assign alu_select_o = gnt_sel;

  assign sel_legal = is_legal_sel(gnt_sel);
  assign gnt_next  = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_valid) begin
      // A grant also covers the retire-and-refill case: the register is simply overwritten.
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_data_d  = sel_legal ? alu_result_i : '0;
      rsp_err_d   = !sel_legal;
      rr_ptr_d    = gnt_next;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
